// File: rtl/sdram_responder_if.sv
// SDR SDRAM command/status bundle between a controller (master) and the device-side responder (slave).
// The data bus DB stays a plain inout port on the responder so tristate resolution is done at the net.
interface sdram_responder_if;
    logic        CKE;
    logic        nCS;
    logic        nRAS;
    logic        nCAS;
    logic        nWE;
    logic [1:0]  BA;
    logic [12:0] ADR;
    logic [1:0]  DQM;
    logic        INIT_DONE;
    logic        ERR;
    logic [2:0]  ERR_CODE;
    logic        RD_ACT;

    modport master (
        output CKE, nCS, nRAS, nCAS, nWE, BA, ADR, DQM,
        input  INIT_DONE, ERR, ERR_CODE, RD_ACT
    );

    modport slave (
        input  CKE, nCS, nRAS, nCAS, nWE, BA, ADR, DQM,
        output INIT_DONE, ERR, ERR_CODE, RD_ACT
    );
endinterface

// File: rtl/sdram_responder.sv
// SDR SDRAM device-side responder: command decode, init tracking, bank/row state, burst storage and read return.
// Define SDRAM_RESP_TIMING_CHECK_EN to enable per-bank T_RCD / T_RP / T_RFC checking (error code 6).
//
// state       | meaning
// S_WAIT_PALL | after reset, waiting for PRECHARGE all banks
// S_WAIT_REF1 | waiting for first AUTO REFRESH
// S_WAIT_REF2 | waiting for second AUTO REFRESH
// S_WAIT_MRS  | waiting for a valid LOAD MODE
// S_READY     | init complete, ACTIVE/READ/WRITE accepted
module sdram_responder #(
    parameter int ROW_BITS = 2,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7
) (
    input  logic             CLK,
    input  logic             nRST,
    sdram_responder_if.slave bus,
    inout  wire  [15:0]      DB
);
    localparam int IDX_W = 2 + ROW_BITS + 8;

    typedef enum logic [2:0] {
        S_WAIT_PALL,
        S_WAIT_REF1,
        S_WAIT_REF2,
        S_WAIT_MRS,
        S_READY
    } init_state_t;

    init_state_t state, state_nxt;

    logic is_act, is_rd, is_wr, is_pre, is_ref, is_mrs, is_bst;
    logic act_ok, rw_ok, mrs_ok, err_hit, t_viol;
    logic [2:0] err_code_nxt;

    logic [7:0] mrs_bl_mask;
    logic       mrs_bl_ok, mrs_cl_ok;
    logic [7:0] bl_mask;
    logic       cl3;
    logic       err_flag;
    logic [2:0] err_code;

    logic [3:0]                bank_open;
    logic [3:0][ROW_BITS-1:0]  bank_row;

    logic             burst_act, burst_wr, burst_ap;
    logic [1:0]       burst_bank;
    logic [7:0]       burst_col, burst_left;
    logic             burst_cut, burst_beat, wr_en, rd_issue, ap_close;
    logic [1:0]       ap_bank;
    logic [IDX_W-1:0] beat_idx;

    logic [15:0]       mem [0:(1<<IDX_W)-1];
    logic [15:0]       mem_q;
    logic [3:0]        rd_v;
    logic [3:0][15:0]  rd_d;
    logic [2:0][1:0]   dqm_p;
    logic [15:0]       dout;
    logic              dvalid;
    logic [1:0]        oe;

    logic unused_bits;
    assign unused_bits = ^{bus.ADR[12:11], bus.ADR[9:8], 32'(T_RCD + T_RP + T_RFC)};

    function automatic logic [7:0] col_next(input logic [7:0] col, input logic [7:0] mask);
        return (col & ~mask) | ((col + 8'd1) & mask);
    endfunction

    always_comb begin
        is_act = 1'b0;
        is_rd  = 1'b0;
        is_wr  = 1'b0;
        is_pre = 1'b0;
        is_ref = 1'b0;
        is_mrs = 1'b0;
        is_bst = 1'b0;
        if (bus.CKE && !bus.nCS) begin
            case ({bus.nRAS, bus.nCAS, bus.nWE})
                3'b011:  is_act = 1'b1;
                3'b101:  is_rd  = 1'b1;
                3'b100:  is_wr  = 1'b1;
                3'b010:  is_pre = 1'b1;
                3'b001:  is_ref = 1'b1;
                3'b000:  is_mrs = 1'b1;
                3'b110:  is_bst = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mrs_bl_mask = 8'h00;
        mrs_bl_ok   = 1'b1;
        case (bus.ADR[2:0])
            3'b000:  mrs_bl_mask = 8'h00;
            3'b001:  mrs_bl_mask = 8'h01;
            3'b010:  mrs_bl_mask = 8'h03;
            3'b011:  mrs_bl_mask = 8'h07;
            3'b111:  mrs_bl_mask = 8'hFF;
            default: mrs_bl_ok   = 1'b0;
        endcase
    end
    assign mrs_cl_ok = (bus.ADR[6:4] == 3'd2) || (bus.ADR[6:4] == 3'd3);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= S_WAIT_PALL;
        else       state <= state_nxt;
    end

    // Command legality, first-error candidate and init sequencing.
    always_comb begin
        state_nxt    = state;
        act_ok       = 1'b0;
        rw_ok        = 1'b0;
        mrs_ok       = 1'b0;
        err_hit      = 1'b0;
        err_code_nxt = 3'd0;
        if (is_act) begin
            if (state != S_READY) begin
                err_hit = 1'b1; err_code_nxt = 3'd1;
            end else if (bank_open[bus.BA]) begin
                err_hit = 1'b1; err_code_nxt = 3'd2;
            end else begin
                act_ok = 1'b1;
            end
        end
        if (is_rd || is_wr) begin
            if (state != S_READY) begin
                err_hit = 1'b1; err_code_nxt = 3'd1;
            end else if (!bank_open[bus.BA]) begin
                err_hit = 1'b1; err_code_nxt = 3'd3;
            end else begin
                rw_ok = 1'b1;
            end
        end
        if (is_mrs) begin
            if (|bank_open) begin
                err_hit = 1'b1; err_code_nxt = 3'd4;
            end else if (!(mrs_bl_ok && mrs_cl_ok)) begin
                err_hit = 1'b1; err_code_nxt = 3'd5;
            end else begin
                mrs_ok = 1'b1;
            end
        end
        if (!err_hit && t_viol) begin
            err_hit = 1'b1; err_code_nxt = 3'd6;
        end
        case (state)
            S_WAIT_PALL: if (is_pre && bus.ADR[10]) state_nxt = S_WAIT_REF1;
            S_WAIT_REF1: if (is_ref) state_nxt = S_WAIT_REF2;
            S_WAIT_REF2: if (is_ref) state_nxt = S_WAIT_MRS;
            S_WAIT_MRS:  if (mrs_ok) state_nxt = S_READY;
            default:     ;
        endcase
    end

    // An interrupted burst drops its pending auto-precharge; only a completed last beat closes the bank.
    always_comb begin
        burst_cut  = burst_act && (rw_ok || is_bst ||
                     (is_pre && (bus.ADR[10] || bus.BA == burst_bank)));
        burst_beat = burst_act && bus.CKE && !burst_cut;
        wr_en      = (rw_ok && is_wr) || (burst_beat && burst_wr);
        rd_issue   = (rw_ok && is_rd) || (burst_beat && !burst_wr);
        beat_idx   = rw_ok ? {bus.BA, bank_row[bus.BA], bus.ADR[7:0]}
                           : {burst_bank, bank_row[burst_bank], burst_col};
        ap_close   = (rw_ok && bus.ADR[10] && bl_mask == 8'h00) ||
                     (burst_beat && burst_ap && burst_left == 8'd1);
        ap_bank    = rw_ok ? bus.BA : burst_bank;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bl_mask  <= 8'h00;
            cl3      <= 1'b0;
            err_flag <= 1'b0;
            err_code <= 3'd0;
        end else begin
            if (mrs_ok) begin
                bl_mask <= mrs_bl_mask;
                cl3     <= bus.ADR[4];
            end
            if (err_hit && !err_flag) begin
                err_flag <= 1'b1;
                err_code <= err_code_nxt;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bank_open <= '0;
            bank_row  <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (act_ok && bus.BA == 2'(b)) begin
                    bank_open[b] <= 1'b1;
                    bank_row[b]  <= bus.ADR[ROW_BITS-1:0];
                end
                if ((is_pre && (bus.ADR[10] || bus.BA == 2'(b))) || (ap_close && ap_bank == 2'(b)))
                    bank_open[b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            burst_act  <= 1'b0;
            burst_wr   <= 1'b0;
            burst_ap   <= 1'b0;
            burst_bank <= 2'd0;
            burst_col  <= 8'd0;
            burst_left <= 8'd0;
        end else if (bus.CKE) begin
            if (rw_ok) begin
                burst_act  <= (bl_mask != 8'h00);
                burst_wr   <= is_wr;
                burst_ap   <= bus.ADR[10];
                burst_bank <= bus.BA;
                burst_col  <= col_next(bus.ADR[7:0], bl_mask);
                burst_left <= bl_mask;
            end else if (burst_cut) begin
                burst_act <= 1'b0;
            end else if (burst_act) begin
                burst_col  <= col_next(burst_col, bl_mask);
                burst_left <= burst_left - 8'd1;
                if (burst_left == 8'd1) burst_act <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (!bus.DQM[0]) mem[beat_idx][7:0]  <= DB[7:0];
            if (!bus.DQM[1]) mem[beat_idx][15:8] <= DB[15:8];
        end
    end
    assign mem_q = mem[beat_idx];

    // Stage 0 is loaded on the issue edge, so stage CL is on the bus from edge cmd+CL+k.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_v  <= '0;
            rd_d  <= '0;
            dqm_p <= '0;
        end else if (bus.CKE) begin
            rd_v  <= {rd_v[2:0], rd_issue};
            rd_d  <= {rd_d[2:0], mem_q};
            dqm_p <= {dqm_p[1:0], bus.DQM};
        end
    end

    assign dout   = cl3 ? rd_d[3] : rd_d[2];
    assign dvalid = cl3 ? rd_v[3] : rd_v[2];
    assign oe     = {2{dvalid}} & ~dqm_p[2];

    assign DB[7:0]  = oe[0] ? dout[7:0]  : 8'hzz;
    assign DB[15:8] = oe[1] ? dout[15:8] : 8'hzz;

    assign bus.RD_ACT    = |oe;
    assign bus.INIT_DONE = (state == S_READY);
    assign bus.ERR       = err_flag;
    assign bus.ERR_CODE  = err_code;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    logic [3:0][7:0] rcd_cnt, rp_cnt;
    logic [7:0]      rfc_cnt;
    logic            is_cmd;

    assign is_cmd = bus.CKE && !bus.nCS && ({bus.nRAS, bus.nCAS, bus.nWE} != 3'b111);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rcd_cnt <= '0;
            rp_cnt  <= '0;
            rfc_cnt <= 8'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (act_ok && bus.BA == 2'(b))
                    rcd_cnt[b] <= 8'(T_RCD - 1);
                else if (rcd_cnt[b] != 8'd0)
                    rcd_cnt[b] <= rcd_cnt[b] - 8'd1;
                if ((is_pre && (bus.ADR[10] || bus.BA == 2'(b))) || (ap_close && ap_bank == 2'(b)))
                    rp_cnt[b] <= 8'(T_RP - 1);
                else if (rp_cnt[b] != 8'd0)
                    rp_cnt[b] <= rp_cnt[b] - 8'd1;
            end
            if (is_ref)
                rfc_cnt <= 8'(T_RFC - 1);
            else if (rfc_cnt != 8'd0)
                rfc_cnt <= rfc_cnt - 8'd1;
        end
    end

    assign t_viol = ((is_rd || is_wr) && rcd_cnt[bus.BA] != 8'd0) ||
                    (is_act && rp_cnt[bus.BA] != 8'd0) ||
                    (is_cmd && rfc_cnt != 8'd0);
`else
    assign t_viol = 1'b0;
`endif

endmodule
